// File: rtl/mcs4_ram_dbg_ctrl.sv
// mcs4_ram_dbg_ctrl: host sequencer for the shared i4002 RAM debug port.
// Define MCS4_DBG_CTRL_STATS_EN to add saturating stat_acc/stat_err counters.
module mcs4_ram_dbg_ctrl #(
    parameter int NUM_RAMS       = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [8:0]  cmd_addr,
    input  logic [8:0]  cmd_len,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic [11:0] dbg_addr,
    output logic [7:0]  dbg_wdata,
    output logic        dbg_wen,
    output logic        dbg_ren,
    input  logic [7:0]  dbg_rdata,
    input  logic        dbg_rdata_vld,
`ifdef MCS4_DBG_CTRL_STATS_EN
    output logic [15:0] stat_acc,
    output logic [15:0] stat_err,
`endif
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT, RSP, WR_DONE} state_t;

    state_t      state, state_n;
    logic        wr_q, err_q, sticky_q;
    logic [8:0]  addr_q, cnt_q;
    logic [7:0]  wdata_q, data_q;
    logic [15:0] tcnt;
    logic        chip_bad, timeout;

    // WRITE and FILL both have op bit 0 set; bulk vs single is folded into cnt_q
    assign chip_bad  = {1'b0, addr_q[8:5]} >= 5'(NUM_RAMS);
    assign timeout   = tcnt == 16'(TIMEOUT_CYCLES - 1);
    assign dbg_addr  = {3'b000, addr_q};
    assign dbg_wdata = wdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and outputs; strobes are masked during reset so an abandoned command never touches a RAM
    always_comb begin
        state_n   = state;
        cmd_ready = state == IDLE;
        busy      = state != IDLE;
        rsp_valid = state == RSP || state == WR_DONE;
        rsp_data  = state == RSP ? data_q : 8'h00;
        rsp_err   = state == RSP ? err_q : (state == WR_DONE ? sticky_q : 1'b0);
        rsp_last  = state == WR_DONE || (state == RSP && cnt_q == 9'd0);
        dbg_ren   = !rst && state == ISSUE && !chip_bad && !wr_q;
        dbg_wen   = !rst && state == ISSUE && !chip_bad && wr_q;
        case (state)
            IDLE:    if (cmd_valid) state_n = ISSUE;
            ISSUE:   state_n = !wr_q ? (chip_bad ? RSP : RD_WAIT) : (cnt_q == 9'd0 ? WR_DONE : ISSUE);
            RD_WAIT: if (dbg_rdata_vld || timeout) state_n = RSP;
            RSP:     if (rsp_ready) state_n = rsp_last ? IDLE : ISSUE;
            WR_DONE: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Command latch, address/count walk, read capture and timeout counting
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q     <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            tcnt     <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    wr_q     <= cmd_op[0];
                    addr_q   <= cmd_addr;
                    cnt_q    <= cmd_op[1] ? cmd_len : 9'd0;
                    wdata_q  <= cmd_wdata;
                    sticky_q <= 1'b0;
                end
                ISSUE: begin
                    tcnt <= '0;
                    if (wr_q) begin
                        if (chip_bad) sticky_q <= 1'b1;
                        if (cnt_q != 9'd0) begin
                            addr_q <= addr_q + 9'd1;
                            cnt_q  <= cnt_q - 9'd1;
                        end
                    end else if (chip_bad) begin
                        data_q <= 8'h00;
                        err_q  <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    tcnt <= tcnt + 16'd1;
                    if (dbg_rdata_vld) begin
                        data_q <= dbg_rdata;
                        err_q  <= 1'b0;
                    end else if (timeout) begin
                        data_q <= 8'h00;
                        err_q  <= 1'b1;
                    end
                end
                RSP: if (rsp_ready && cnt_q != 9'd0) begin
                    addr_q <= addr_q + 9'd1;
                    cnt_q  <= cnt_q - 9'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef MCS4_DBG_CTRL_STATS_EN
    logic byte_err;

    assign byte_err = (state == ISSUE && chip_bad) || (state == RD_WAIT && !dbg_rdata_vld && timeout);

    // Saturating counts of issued strobes and errored bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_acc <= '0;
            stat_err <= '0;
        end else begin
            if ((dbg_ren || dbg_wen) && stat_acc != 16'hFFFF) stat_acc <= stat_acc + 16'd1;
            if (byte_err && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
        end
    end
`endif
endmodule
